// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multicycle MIPS control unit: state encoding, ALU operations,
// opcode/func_code values, instruction classes and the per-cycle control vector.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH         = 3'd0,
    DECODE        = 3'd1,
    EXECUTE       = 3'd2,
    MEMORY_ACCESS = 3'd3,
    WRITE_BACK    = 3'd4,
    HALT          = 3'd5
  } state_t;

  // Signed/unsigned variants share an encoding; the unsign line selects between them.
  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_NOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_MULT = 4'd10,
    ALU_DIV  = 4'd11
  } ALUOperation_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
    OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
    OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03, FN_JR   = 6'h08,
    FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU = 6'h1B,
    FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR   = 6'h25,
    FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B
  } func_t;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE,
    CLS_MULDIV, CLS_JUMP, CLS_BEQ, CLS_BNE
  } instr_class_t;

  typedef struct packed {
    logic          RegDst;
    logic          RegWrite;
    logic          ALUSrcA;
    logic          IorD;
    logic          MemRead;
    logic          MemWrite;
    logic          MemtoReg;
    logic          IRWrite;
    logic          PCWrite;
    logic          unsign;
    logic          fixed_shift;
    logic [1:0]    ALUSrcB;
    ALUOperation_t ALUctl;
    logic [1:0]    PCSource;
    logic          TargetWrite;
    logic          HiLoWrite;
    logic [3:0]    byteenable;
  } ctrl_t;

  function automatic instr_class_t classify(logic [5:0] op, logic [5:0] fn);
    instr_class_t c;
    c = CLS_NONE;
    case (opcode_t'(op))
      OP_RTYPE: begin
        case (func_t'(fn))
          FN_JR:                              c = CLS_JUMP;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: c = CLS_MULDIV;
          FN_SLL, FN_SRL, FN_SRA, FN_ADDU, FN_SUBU, FN_AND,
          FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: c = CLS_ALU_R;
          default:                            c = CLS_NONE;
        endcase
      end
      OP_J:                                        c = CLS_JUMP;
      OP_BEQ:                                      c = CLS_BEQ;
      OP_BNE:                                      c = CLS_BNE;
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: c = CLS_ALU_I;
      OP_LW:                                       c = CLS_LOAD;
      OP_SW:                                       c = CLS_STORE;
      default:                                     c = CLS_NONE;
    endcase
    return c;
  endfunction

  function automatic ALUOperation_t alu_op(logic [5:0] op, logic [5:0] fn);
    ALUOperation_t a;
    a = ALU_ADD;
    case (opcode_t'(op))
      OP_RTYPE: begin
        case (func_t'(fn))
          FN_SLL:            a = ALU_SLL;
          FN_SRL:            a = ALU_SRL;
          FN_SRA:            a = ALU_SRA;
          FN_SUBU:           a = ALU_SUB;
          FN_AND:            a = ALU_AND;
          FN_OR:             a = ALU_OR;
          FN_XOR:            a = ALU_XOR;
          FN_NOR:            a = ALU_NOR;
          FN_SLT, FN_SLTU:   a = ALU_SLT;
          FN_MULT, FN_MULTU: a = ALU_MULT;
          FN_DIV, FN_DIVU:   a = ALU_DIV;
          default:           a = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE:      a = ALU_SUB;
      OP_SLTI, OP_SLTIU:   a = ALU_SLT;
      OP_ANDI:             a = ALU_AND;
      OP_ORI:              a = ALU_OR;
      OP_XORI:             a = ALU_XOR;
      default:             a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Unsigned compare, unsigned mult/div, and zero-extended logical immediates.
  function automatic logic is_unsigned(logic [5:0] op, logic [5:0] fn);
    if (opcode_t'(op) == OP_RTYPE)
      return func_t'(fn) inside {FN_SLTU, FN_MULTU, FN_DIVU};
    return opcode_t'(op) inside {OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  function automatic logic branch_taken(instr_class_t c, logic cond);
    case (c)
      CLS_JUMP: return 1'b1;
      CLS_BEQ:  return cond;
      CLS_BNE:  return !cond;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_control_fsm_if.sv
// Control-unit bus: IR fields and datapath status in, datapath enables/selects out.
interface mips_control_fsm_if #(
  parameter int STATE_W = 3
);
  import mips_ctrl_pkg::*;

  logic [5:0]         opcode;
  logic [5:0]         func_code;
  logic               waitrequest;
  logic               branch_cond;
  logic               jump_to_zero;

  logic [STATE_W-1:0] state;
  logic               active;
  logic               RegDst, RegWrite, ALUSrcA, IorD, MemRead, MemWrite;
  logic               MemtoReg, IRWrite, PCWrite, unsign, fixed_shift;
  logic [1:0]         ALUSrcB;
  ALUOperation_t      ALUctl;
  logic [1:0]         PCSource;
  logic               TargetWrite;
  logic               HiLoWrite;
  logic [3:0]         byteenable;

  modport master (
    input  opcode, func_code, waitrequest, branch_cond, jump_to_zero,
    output state, active, RegDst, RegWrite, ALUSrcA, IorD, MemRead, MemWrite,
           MemtoReg, IRWrite, PCWrite, unsign, fixed_shift, ALUSrcB, ALUctl,
           PCSource, TargetWrite, HiLoWrite, byteenable
  );

  modport slave (
    output opcode, func_code, waitrequest, branch_cond, jump_to_zero,
    input  state, active, RegDst, RegWrite, ALUSrcA, IorD, MemRead, MemWrite,
           MemtoReg, IRWrite, PCWrite, unsign, fixed_shift, ALUSrcB, ALUctl,
           PCSource, TargetWrite, HiLoWrite, byteenable
  );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational control decode: (state, IR fields, status) -> datapath control vector.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] func_code,
  input  logic       branch_cond,
  input  logic       waitrequest,
  input  logic       delay_pending,
  input  logic       halt_pending,
  input  logic       muldiv_last,
  output ctrl_t      ctrl
);

  instr_class_t cls;
  assign cls = classify(opcode, func_code);

  always_comb begin
    // NOTE: every field gets its default first, so no branch below can infer a latch.
    ctrl         = '0;
    ctrl.ALUSrcA = 1'b1;
    ctrl.ALUctl  = ALU_ADD;

    case (state)
      FETCH: begin
        // A pending halt with no delay slot outstanding suppresses the fetch entirely.
        if (!(halt_pending && !delay_pending)) begin
          ctrl.MemRead  = 1'b1;
          ctrl.IorD     = 1'b0;
          ctrl.ALUSrcA  = 1'b0;
          ctrl.ALUSrcB  = 2'd1;
          ctrl.PCWrite  = !waitrequest;
          ctrl.PCSource = delay_pending ? 2'd2 : 2'd0;
        end
      end

      DECODE: begin
        ctrl.IRWrite = 1'b1;
        ctrl.ALUSrcA = 1'b0;
        ctrl.ALUSrcB = 2'd2;
      end

      EXECUTE: begin
        ctrl.ALUctl = alu_op(opcode, func_code);
        ctrl.unsign = is_unsigned(opcode, func_code);
        case (cls)
          CLS_ALU_R: ctrl.fixed_shift = func_t'(func_code) inside {FN_SLL, FN_SRL, FN_SRA};
          CLS_ALU_I, CLS_LOAD, CLS_STORE: ctrl.ALUSrcB = 2'd3;
          CLS_MULDIV: ctrl.HiLoWrite = muldiv_last;
          CLS_JUMP, CLS_BEQ, CLS_BNE: ctrl.TargetWrite = branch_taken(cls, branch_cond);
          default: ;
        endcase
      end

      MEMORY_ACCESS: begin
        case (cls)
          CLS_LOAD: begin
            ctrl.MemRead    = 1'b1;
            ctrl.IorD       = 1'b1;
            ctrl.byteenable = 4'b1111;
          end
          CLS_STORE: begin
            ctrl.MemWrite   = 1'b1;
            ctrl.IorD       = 1'b1;
            ctrl.byteenable = 4'b1111;
          end
          CLS_ALU_R: begin
            ctrl.RegWrite = 1'b1;
            ctrl.RegDst   = 1'b1;
          end
          CLS_ALU_I: ctrl.RegWrite = 1'b1;
          default: ;
        endcase
      end

      WRITE_BACK: begin
        ctrl.RegWrite = 1'b1;
        ctrl.MemtoReg = 1'b1;
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: state register, mult/div hold counter, delay-slot and
// halt tracking; per-state controls come from mips_ctrl_decode.
module mips_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 33,
  parameter int STATE_W       = 3
) (
  input logic                clk,
  input logic                reset,
  mips_control_fsm_if.master bus
);

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         delay_pending_q, delay_pending_d;
  logic         halt_pending_q, halt_pending_d;
  logic         muldiv_last;
  instr_class_t cls;
  ctrl_t        ctrl_raw, ctrl_out;

  assign cls         = classify(bus.opcode, bus.func_code);
  assign muldiv_last = (cnt_q == CNT_W'(MULDIV_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= FETCH;
      cnt_q           <= '0;
      delay_pending_q <= 1'b0;
      halt_pending_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking, so each register samples its peers' pre-edge values.
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      delay_pending_q <= delay_pending_d;
      halt_pending_q  <= halt_pending_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    delay_pending_d = delay_pending_q;
    halt_pending_d  = halt_pending_q;

    case (state_q)
      FETCH: begin
        if (halt_pending_q && !delay_pending_q) begin
          state_d = HALT;
        end else if (!bus.waitrequest) begin
          state_d         = DECODE;
          delay_pending_d = 1'b0;
        end
      end

      DECODE: state_d = EXECUTE;

      EXECUTE: begin
        case (cls)
          CLS_MULDIV: begin
            if (muldiv_last) begin
              state_d = FETCH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          CLS_JUMP, CLS_BEQ, CLS_BNE: begin
            state_d = FETCH;
            // A taken branch in a delay slot replaces the earlier target, halt flag included.
            if (branch_taken(cls, bus.branch_cond)) begin
              delay_pending_d = 1'b1;
              halt_pending_d  = bus.jump_to_zero;
            end
          end
          CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE: state_d = MEMORY_ACCESS;
          default: state_d = FETCH;
        endcase
      end

      MEMORY_ACCESS: begin
        case (cls)
          CLS_LOAD:  if (!bus.waitrequest) state_d = WRITE_BACK;
          CLS_STORE: if (!bus.waitrequest) state_d = FETCH;
          default:   state_d = FETCH;
        endcase
      end

      WRITE_BACK: state_d = FETCH;
      HALT:       state_d = HALT;
      default:    state_d = FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state         (state_q),
    .opcode        (bus.opcode),
    .func_code     (bus.func_code),
    .branch_cond   (bus.branch_cond),
    .waitrequest   (bus.waitrequest),
    .delay_pending (delay_pending_q),
    .halt_pending  (halt_pending_q),
    .muldiv_last   (muldiv_last),
    .ctrl          (ctrl_raw)
  );

  always_comb begin
    ctrl_out = ctrl_raw;
    // Reset state is FETCH, which would otherwise drive a memory read during reset.
    if (reset) begin
      ctrl_out.RegWrite    = 1'b0;
      ctrl_out.MemRead     = 1'b0;
      ctrl_out.MemWrite    = 1'b0;
      ctrl_out.IRWrite     = 1'b0;
      ctrl_out.PCWrite     = 1'b0;
      ctrl_out.TargetWrite = 1'b0;
      ctrl_out.HiLoWrite   = 1'b0;
      ctrl_out.byteenable  = '0;
    end

    bus.state       = STATE_W'(state_q);
    bus.active      = (state_q != HALT);
    bus.RegDst      = ctrl_out.RegDst;
    bus.RegWrite    = ctrl_out.RegWrite;
    bus.ALUSrcA     = ctrl_out.ALUSrcA;
    bus.IorD        = ctrl_out.IorD;
    bus.MemRead     = ctrl_out.MemRead;
    bus.MemWrite    = ctrl_out.MemWrite;
    bus.MemtoReg    = ctrl_out.MemtoReg;
    bus.IRWrite     = ctrl_out.IRWrite;
    bus.PCWrite     = ctrl_out.PCWrite;
    bus.unsign      = ctrl_out.unsign;
    bus.fixed_shift = ctrl_out.fixed_shift;
    bus.ALUSrcB     = ctrl_out.ALUSrcB;
    bus.ALUctl      = ctrl_out.ALUctl;
    bus.PCSource    = ctrl_out.PCSource;
    bus.TargetWrite = ctrl_out.TargetWrite;
    bus.HiLoWrite   = ctrl_out.HiLoWrite;
    bus.byteenable  = ctrl_out.byteenable;
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: expected per-cycle control vectors are queued by
// the stimulus and compared by a negedge monitor.
module tb_mips_control_fsm;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] state;
    logic       active;
    logic       RegDst, RegWrite, ALUSrcA, IorD, MemRead, MemWrite;
    logic       MemtoReg, IRWrite, PCWrite, unsign, fixed_shift;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUctl;
    logic [1:0] PCSource;
    logic       TargetWrite, HiLoWrite;
    logic [3:0] byteenable;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];
  string tag_q[$];
  obs_t act;

  mips_control_fsm_if #(.STATE_W(3)) bus ();

  mips_control_fsm #(.MULDIV_CYCLES(33), .STATE_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    act.state       = bus.state;
    act.active      = bus.active;
    act.RegDst      = bus.RegDst;
    act.RegWrite    = bus.RegWrite;
    act.ALUSrcA     = bus.ALUSrcA;
    act.IorD        = bus.IorD;
    act.MemRead     = bus.MemRead;
    act.MemWrite    = bus.MemWrite;
    act.MemtoReg    = bus.MemtoReg;
    act.IRWrite     = bus.IRWrite;
    act.PCWrite     = bus.PCWrite;
    act.unsign      = bus.unsign;
    act.fixed_shift = bus.fixed_shift;
    act.ALUSrcB     = bus.ALUSrcB;
    act.ALUctl      = bus.ALUctl;
    act.PCSource    = bus.PCSource;
    act.TargetWrite = bus.TargetWrite;
    act.HiLoWrite   = bus.HiLoWrite;
    act.byteenable  = bus.byteenable;
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t  w;
      string t;
      w = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'(act), 32'(w));
    end
  end

  // Hand-written expected vectors per state.
  function automatic obs_t dflt(state_t s);
    obs_t e;
    e         = '0;
    e.state   = s;
    e.active  = (s != HALT);
    e.ALUSrcA = 1'b1;
    e.ALUctl  = ALU_ADD;
    return e;
  endfunction

  function automatic obs_t fetch_e(logic pw, logic [1:0] ps);
    obs_t e;
    e          = dflt(FETCH);
    e.MemRead  = 1'b1;
    e.ALUSrcA  = 1'b0;
    e.ALUSrcB  = 2'd1;
    e.PCWrite  = pw;
    e.PCSource = ps;
    return e;
  endfunction

  function automatic obs_t rst_e();
    obs_t e;
    e         = fetch_e(1'b0, 2'd0);
    e.MemRead = 1'b0;
    return e;
  endfunction

  function automatic obs_t decode_e();
    obs_t e;
    e         = dflt(DECODE);
    e.IRWrite = 1'b1;
    e.ALUSrcA = 1'b0;
    e.ALUSrcB = 2'd2;
    return e;
  endfunction

  function automatic obs_t exec_e(logic [1:0] srcb, ALUOperation_t op);
    obs_t e;
    e         = dflt(EXECUTE);
    e.ALUSrcB = srcb;
    e.ALUctl  = op;
    return e;
  endfunction

  function automatic obs_t mem_e(logic store);
    obs_t e;
    e            = dflt(MEMORY_ACCESS);
    e.IorD       = 1'b1;
    e.byteenable = 4'hF;
    e.MemRead    = !store;
    e.MemWrite   = store;
    return e;
  endfunction

  task automatic step(string tag, obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(logic [5:0] op, logic [5:0] fn);
    bus.opcode    = op;
    bus.func_code = fn;
  endtask

  task automatic run_alu(string tag, logic [5:0] op, logic [5:0] fn, obs_t ex,
                         logic regdst, logic [1:0] pcsrc);
    obs_t m;
    set_ir(op, fn);
    step({tag, "_fetch"}, fetch_e(1'b1, pcsrc));
    step({tag, "_decode"}, decode_e());
    step({tag, "_exec"}, ex);
    m          = dflt(MEMORY_ACCESS);
    m.RegWrite = 1'b1;
    m.RegDst   = regdst;
    step({tag, "_mem"}, m);
  endtask

  task automatic run_mult(string tag);
    obs_t e;
    set_ir(OP_RTYPE, FN_MULT);
    step({tag, "_fetch"}, fetch_e(1'b1, 2'd0));
    bus.waitrequest = 1'b1;
    step({tag, "_decode"}, decode_e());
    for (int i = 1; i <= 33; i++) begin
      e           = exec_e(2'd0, ALU_MULT);
      e.HiLoWrite = (i == 33);
      step({tag, "_exec"}, e);
    end
    bus.waitrequest = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    reset            = 1'b1;
    bus.opcode       = '0;
    bus.func_code    = '0;
    bus.waitrequest  = 1'b0;
    bus.branch_cond  = 1'b0;
    bus.jump_to_zero = 1'b0;
    @(posedge clk);
    #1;
    step("reset", rst_e());
    step("reset", rst_e());
    reset = 1'b0;

    run_alu("addu", OP_RTYPE, FN_ADDU, exec_e(2'd0, ALU_ADD), 1'b1, 2'd0);

    // LW with three stall cycles in MEMORY_ACCESS.
    set_ir(OP_LW, 6'h00);
    step("lw_fetch", fetch_e(1'b1, 2'd0));
    step("lw_decode", decode_e());
    step("lw_exec", exec_e(2'd3, ALU_ADD));
    bus.waitrequest = 1'b1;
    repeat (3) step("lw_mem_stall", mem_e(1'b0));
    bus.waitrequest = 1'b0;
    step("lw_mem", mem_e(1'b0));
    e          = dflt(WRITE_BACK);
    e.RegWrite = 1'b1;
    e.MemtoReg = 1'b1;
    step("lw_wb", e);

    // SW with two stall cycles in FETCH.
    set_ir(OP_SW, 6'h00);
    bus.waitrequest = 1'b1;
    repeat (2) step("sw_fetch_stall", fetch_e(1'b0, 2'd0));
    bus.waitrequest = 1'b0;
    step("sw_fetch", fetch_e(1'b1, 2'd0));
    step("sw_decode", decode_e());
    step("sw_exec", exec_e(2'd3, ALU_ADD));
    step("sw_mem", mem_e(1'b1));

    run_mult("mult");

    // BEQ taken, ADDIU in its delay slot, then BNE not taken.
    set_ir(OP_BEQ, 6'h00);
    step("beq_fetch", fetch_e(1'b1, 2'd0));
    step("beq_decode", decode_e());
    bus.branch_cond = 1'b1;
    e               = exec_e(2'd0, ALU_SUB);
    e.TargetWrite   = 1'b1;
    step("beq_exec", e);
    bus.branch_cond = 1'b0;
    run_alu("slot_addiu", OP_ADDIU, 6'h00, exec_e(2'd3, ALU_ADD), 1'b0, 2'd2);

    set_ir(OP_BNE, 6'h00);
    step("bne_fetch", fetch_e(1'b1, 2'd0));
    step("bne_decode", decode_e());
    bus.branch_cond = 1'b1;
    step("bne_exec", exec_e(2'd0, ALU_SUB));
    bus.branch_cond = 1'b0;

    set_ir(6'h3F, 6'h00);
    step("unk_fetch", fetch_e(1'b1, 2'd0));
    step("unk_decode", decode_e());
    step("unk_exec", dflt(EXECUTE));

    e        = exec_e(2'd3, ALU_SLT);
    e.unsign = 1'b1;
    run_alu("sltiu", OP_SLTIU, 6'h00, e, 1'b0, 2'd0);
    e             = exec_e(2'd0, ALU_SLL);
    e.fixed_shift = 1'b1;
    run_alu("sll", OP_RTYPE, FN_SLL, e, 1'b1, 2'd0);

    // JR to address zero: delay slot completes, then the CPU halts.
    set_ir(OP_RTYPE, FN_JR);
    step("jr_fetch", fetch_e(1'b1, 2'd0));
    step("jr_decode", decode_e());
    bus.jump_to_zero = 1'b1;
    e                = exec_e(2'd0, ALU_ADD);
    e.TargetWrite    = 1'b1;
    step("jr_exec", e);
    bus.jump_to_zero = 1'b0;
    run_alu("slot_addu", OP_RTYPE, FN_ADDU, exec_e(2'd0, ALU_ADD), 1'b1, 2'd2);
    step("halt_entry", dflt(FETCH));
    bus.waitrequest = 1'b1;
    repeat (100) step("halt", dflt(HALT));
    bus.waitrequest = 1'b0;

    reset = 1'b1;
    step("halt_reset", rst_e());
    step("halt_reset", rst_e());
    reset = 1'b0;

    // Reset arriving between clock edges during a FETCH stall.
    set_ir(OP_RTYPE, FN_ADDU);
    bus.waitrequest = 1'b1;
    step("fstall", fetch_e(1'b0, 2'd0));
    exp_q.push_back(rst_e());
    tag_q.push_back("fstall_async_rst");
    #1;
    check("fstall_memread_held", 32'(bus.MemRead), 32'(1'b1));
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_state", 32'(bus.state), 32'(FETCH));
    check("async_rst_memread", 32'(bus.MemRead), 32'(1'b0));
    @(posedge clk);
    #1;
    step("fstall_rst_hold", rst_e());
    reset           = 1'b0;
    bus.waitrequest = 1'b0;
    run_alu("addu_after_rst", OP_RTYPE, FN_ADDU, exec_e(2'd0, ALU_ADD), 1'b1, 2'd0);

    // Reset arriving mid-MULT; the next MULT must again take the full count.
    set_ir(OP_RTYPE, FN_MULT);
    step("pmult_fetch", fetch_e(1'b1, 2'd0));
    step("pmult_decode", decode_e());
    repeat (10) step("pmult_exec", exec_e(2'd0, ALU_MULT));
    exp_q.push_back(rst_e());
    tag_q.push_back("mult_async_rst");
    #2;
    reset = 1'b1;
    #1;
    check("mult_async_rst_state", 32'(bus.state), 32'(FETCH));
    @(posedge clk);
    #1;
    step("mult_rst_hold", rst_e());
    reset = 1'b0;
    run_mult("mult_after_rst");
    step("final_fetch", fetch_e(1'b1, 2'd0));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_control_fsm.md
# mips_control_fsm

Multicycle MIPS control unit that owns its own state register, replacing the externally-sequenced combinational decoder. Sits between the instruction register fields and the datapath: generates every datapath enable/select per state. Adds memory wait-state handling, multi-cycle MULT/DIV, taken-branch/jump with one delay slot, and halt-on-jump-to-zero.

## Interface
- MULDIV_CYCLES, 33: cycles the EXECUTE state is held for MULT/MULTU/DIV/DIVU (≥1).
- STATE_W, 3: width of the state encoding.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  IR[31:26]; func_code  in  6  IR[5:0].
- waitrequest  in  1  memory stall; valid in FETCH and MEMORY_ACCESS only.
- branch_cond  in  1  ALU comparison result (rs==rt) during EXECUTE.
- jump_to_zero  in  1  computed jump/branch target equals 0x00000000 during EXECUTE.
- state  out  STATE_W  current state.
- active  out  1  high while CPU runs; low in HALT.
- RegDst, RegWrite, ALUSrcA, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCWrite, unsign, fixed_shift  out  1 each.
- ALUSrcB  out  2; ALUctl  out  4; PCSource  out  2  (0 ALU, 1 ALUOut, 2 target register).
- TargetWrite  out  1  latch jump/branch target into target register.
- HiLoWrite  out  1  commit mult/div result to HI/LO.
- byteenable  out  4  4'b1111 on LW/SW memory cycles, else 0.

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY_ACCESS=3, WRITE_BACK=4, HALT=5.
- Internal regs: state, muldiv counter, delay_pending, halt_pending.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUctl=ADD. Stay while waitrequest. On exit: PCWrite=1; PCSource=2 if delay_pending else 0; delay_pending clears. If halt_pending and delay_pending==0 on entry → HALT instead of fetching.
- DECODE: IRWrite=1, ALUSrcA=0, ALUSrcB=2, ALUctl=ADD → EXECUTE.
- EXECUTE: ALU ops as existing decode (R-type ALU on func_code, ADDIU/SLTI/SLTIU/ANDI/ORI/XORI, LW/SW address with ALUSrcB=3).
  - MULT/MULTU/DIV/DIVU: hold MULDIV_CYCLES cycles; HiLoWrite=1 on last cycle only → FETCH.
  - J/JR, BEQ (branch_cond=1), BNE (branch_cond=0): TargetWrite=1, set delay_pending; halt_pending set if jump_to_zero → FETCH. Untaken branch → FETCH, no flags.
  - LW/SW/ALU ops → MEMORY_ACCESS. Unknown opcode → FETCH, no writes.
- MEMORY_ACCESS: LW MemRead=1, SW MemWrite=1, IorD=1, byteenable=4'b1111, hold while waitrequest; LW → WRITE_BACK, SW → FETCH. ALU ops: RegWrite=1 (RegDst=1 R-type, 0 I-type), MemtoReg=0 → FETCH.
- WRITE_BACK: RegWrite=1, RegDst=0, MemtoReg=1 → FETCH.
- HALT: active=0, all enables 0; exits only via reset.
- Defaults each cycle: all enables 0, ALUSrcA=1, byteenable=0.

## Timing
- Reset (async): state=FETCH, active=1, counter=0, delay_pending=0, halt_pending=0; while reset high all write/read enables forced 0.
- Latency with waitrequest=0: ALU op 4 cycles, SW 4, LW 5, jump/branch 3, mult/div 2+MULDIV_CYCLES.
- Write strobes (PCWrite, RegWrite, MemWrite, HiLoWrite) are single-cycle; never asserted during a stall cycle except MemRead/MemWrite held.
- waitrequest outside FETCH/MEMORY_ACCESS ignored.
- Branch inside delay slot: second TargetWrite overwrites; delay_pending stays set (last target wins).
- Reset mid-stall or mid-mult: immediate return to FETCH, counter cleared.

## Structure
- Package mips_ctrl_pkg: state_t (incl. HALT), ALUOperation_t, opcode and func_code enums, shared with datapath and ALU.
- Sub-module mips_ctrl_decode: combinational (state, opcode, func_code, branch_cond) → control vector; top holds registers and transitions.

## Test plan
- ADDU with waitrequest=0 → states 0,1,2,3,0; RegWrite=1,RegDst=1 only in state 3; one PCWrite.
- LW with waitrequest high 3 cycles in MEMORY_ACCESS → MemRead, IorD=1, byteenable=4'hF held 4 cycles, then WRITE_BACK with MemtoReg=1.
- MULT, MULDIV_CYCLES=33 → EXECUTE held 33 cycles, HiLoWrite exactly once on cycle 33, no RegWrite.
- BEQ taken then ADDIU delay slot → TargetWrite once; delay-slot FETCH exits with PCSource=2; BNE with branch_cond=1 → no TargetWrite.
- JR with jump_to_zero=1 → delay slot executes fully, next FETCH goes HALT, active=0, all strobes 0 for 100 cycles.
- Assert reset during FETCH stall → state=0 asynchronously, MemRead=0 until release, then normal fetch.
